// File: rtl/pwm_seq_pkg.sv
// rtl/pwm_seq_pkg.sv - shared state encoding and duty table functions for pwm_seq_ctrl
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_SEEK  = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_t;

    localparam int SINE_DEPTH = 36;
    localparam int POS_CODES  = 16;

    // sin(a * 10 deg) scaled by 2**16, first quadrant only (a = 0..9)
    function automatic int sin_q16(input int a);
        int s;
        case (a)
            0:       s = 0;
            1:       s = 11380;
            2:       s = 22415;
            3:       s = 32768;
            4:       s = 42125;
            5:       s = 50203;
            6:       s = 56756;
            7:       s = 61584;
            8:       s = 64540;
            default: s = 65536;
        endcase
        return s;
    endfunction

    // floor(2**r * (0.5 + 0.5*sin(2*pi*k/36))), clipped to 2**r-1
    function automatic int sine_duty(input int r, input int k);
        int     a;
        int     m;
        logic   neg;
        longint v;
        a = k % SINE_DEPTH;
        if (a <= 9) begin
            m = sin_q16(a);
            neg = 1'b0;
        end else if (a <= 18) begin
            m = sin_q16(18 - a);
            neg = 1'b0;
        end else if (a <= 27) begin
            m = sin_q16(a - 18);
            neg = 1'b1;
        end else begin
            m = sin_q16(36 - a);
            neg = 1'b1;
        end
        v = neg ? longint'(65536 - m) : longint'(65536 + m);
        v = (v << r) >> 17;
        if (v > ((longint'(1) << r) - 1)) begin
            v = (longint'(1) << r) - 1;
        end
        return int'(v);
    endfunction

    // floor(p * (2**r - 1) / 15)
    function automatic int pos2duty(input int r, input int p);
        return (p * ((1 << r) - 1)) / 15;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - PWM period counter, period-aligned duty register and registered compare
module pwm_core
    import pwm_seq_pkg::*;
#(
    parameter int R = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [R-1:0] duty_next,
    input  logic         load,
    output logic [R-1:0] duty,
    output logic         period_tick,
    output logic         pwm_out
);

    localparam logic [R-1:0] Q_MAX = {R{1'b1}};

    logic [R-1:0] q;
    logic [R-1:0] q_nxt;
    logic [R-1:0] duty_nxt;

    assign period_tick = (q == Q_MAX);
    assign q_nxt       = q + R'(1);
    assign duty_nxt    = (period_tick && load) ? duty_next : duty;

    // counter wraps naturally; pwm_out is precomputed so it equals (q < duty) each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            q       <= q_nxt;
            duty    <= duty_nxt;
            pwm_out <= (q_nxt < duty_nxt);
        end
    end

endmodule

// File: rtl/pwm_seq_ctrl.sv
// rtl/pwm_seq_ctrl.sv - sweep/seek duty sequencer driving a single PWM channel
module pwm_seq_ctrl
    import pwm_seq_pkg::*;
#(
    parameter int R            = 6,
    parameter int STEP_PERIODS = 4000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sweep_start,
    input  logic         stop,
    input  logic [3:0]   pos_t,
    input  logic         seek_valid,
    output logic         seek_ready,
    output logic         pwm_out,
    output logic [R-1:0] duty,
    output logic [1:0]   state,
    output logic [5:0]   step_idx,
    output logic         period_tick,
    output logic         at_target
);

    localparam logic [15:0] STEP_LAST = 16'(STEP_PERIODS - 1);
    localparam logic [5:0]  IDX_LAST  = 6'(SINE_DEPTH - 1);

    seq_state_t   st;
    seq_state_t   st_nxt;
    logic [5:0]   idx_nxt;
    logic [15:0]  cnt;
    logic [15:0]  cnt_nxt;
    logic [R-1:0] target;
    logic [R-1:0] duty_next;
    logic         load;
    logic         hs;
    logic         cmd;
    logic         slew;
    logic         step_evt;

    logic [R-1:0] sine_rom [SINE_DEPTH];
    logic [R-1:0] pos_rom  [POS_CODES];

    genvar gi;
    generate
        for (gi = 0; gi < SINE_DEPTH; gi++) begin : g_sine
            assign sine_rom[gi] = R'(sine_duty(R, gi));
        end
        for (gi = 0; gi < POS_CODES; gi++) begin : g_pos
            assign pos_rom[gi] = R'(pos2duty(R, gi));
        end
    endgenerate

    assign seek_ready = (st != ST_SEEK);
    assign at_target  = (st == ST_HOLD);
    assign state      = st;
    assign hs         = seek_valid && seek_ready;
    assign step_evt   = period_tick && (cnt == STEP_LAST);

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= ST_IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    // commands take priority (stop > seek > sweep); otherwise the current state's step action runs
    always_comb begin
        st_nxt  = st;
        idx_nxt = step_idx;
        cmd     = 1'b0;
        slew    = 1'b0;
        if (stop) begin
            st_nxt = ST_IDLE;
            cmd    = 1'b1;
        end else if (hs) begin
            st_nxt = ST_SEEK;
            cmd    = 1'b1;
        end else if (sweep_start && (st != ST_SEEK)) begin
            st_nxt  = ST_SWEEP;
            idx_nxt = '0;
            cmd     = 1'b1;
        end else begin
            case (st)
                ST_SWEEP: begin
                    if (step_evt) begin
                        idx_nxt = (step_idx == IDX_LAST) ? 6'd0 : step_idx + 6'd1;
                    end
                end
                ST_SEEK: begin
                    if (duty == target) begin
                        st_nxt = ST_HOLD;
                    end else if (step_evt) begin
                        slew = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // duty the core adopts at the next period boundary, chosen by the state being entered
    always_comb begin
        duty_next = duty;
        load      = 1'b0;
        if (st_nxt == ST_IDLE) begin
            duty_next = '0;
            load      = 1'b1;
        end else if (st_nxt == ST_SWEEP) begin
            duty_next = sine_rom[idx_nxt];
            load      = 1'b1;
        end else if (slew) begin
            duty_next = (duty < target) ? duty + R'(1) : duty - R'(1);
            load      = 1'b1;
        end
    end

    // step counter restarts on every command or state change, else counts periods
    always_comb begin
        cnt_nxt = cnt;
        if (cmd || (st_nxt != st)) begin
            cnt_nxt = '0;
        end else if (period_tick) begin
            cnt_nxt = (cnt == STEP_LAST) ? 16'd0 : cnt + 16'd1;
        end
    end

    // sequencer datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_idx <= '0;
            cnt      <= '0;
            target   <= '0;
        end else begin
            step_idx <= idx_nxt;
            cnt      <= cnt_nxt;
            if (hs && !stop) begin
                target <= pos_rom[pos_t];
            end
        end
    end

    pwm_core #(.R(R)) u_core (
        .clk         (clk),
        .rst         (rst),
        .duty_next   (duty_next),
        .load        (load),
        .duty        (duty),
        .period_tick (period_tick),
        .pwm_out     (pwm_out)
    );

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb/tb_pwm_seq_ctrl.sv - scoreboard bench for pwm_seq_ctrl with a period-level reference model
module tb_pwm_seq_ctrl;

    localparam int R   = 6;
    localparam int SP  = 2;
    localparam int PER = 64;
    localparam int M_IDLE = 0, M_SWEEP = 1, M_SEEK = 2, M_HOLD = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sweep_start = 1'b0;
    logic         stop = 1'b0;
    logic [3:0]   pos_t = 4'd0;
    logic         seek_valid = 1'b0;
    logic         seek_ready;
    logic         pwm_out;
    logic [R-1:0] duty;
    logic [1:0]   state;
    logic [5:0]   step_idx;
    logic         period_tick;
    logic         at_target;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int duty;
        int state;
        int idx;
        int at_tgt;
        int rdy;
    } exp_t;

    exp_t sb[$];

    int sine_tab[36];
    int m_q, m_state, m_duty, m_idx, m_cnt, m_tgt;
    bit m_tick_seen;

    pwm_seq_ctrl #(.R(R), .STEP_PERIODS(SP)) dut (
        .clk         (clk),
        .rst         (rst),
        .sweep_start (sweep_start),
        .stop        (stop),
        .pos_t       (pos_t),
        .seek_valid  (seek_valid),
        .seek_ready  (seek_ready),
        .pwm_out     (pwm_out),
        .duty        (duty),
        .state       (state),
        .step_idx    (step_idx),
        .period_tick (period_tick),
        .at_target   (at_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sine_ref(input int k);
        real v;
        int  r;
        v = 64.0 * (0.5 + 0.5 * $sin(2.0 * 3.141592653589793 * k / 36.0)) + 1.0e-9;
        r = int'($floor(v));
        if (r > PER - 1) r = PER - 1;
        if (r < 0) r = 0;
        return r;
    endfunction

    task automatic model_reset();
        m_q = 0; m_state = M_IDLE; m_duty = 0; m_idx = 0; m_cnt = 0; m_tgt = 0;
    endtask

    // one clock of the reference: rules applied to the cycle whose inputs are given
    task automatic model_cycle(input bit ss, input bit sp, input bit sv, input int pos);
        bit   tick, stepev, hs, cmd, slew;
        int   ns;
        exp_t e;
        tick = (m_q == PER - 1);
        if (tick) begin
            e.duty = m_duty; e.state = m_state; e.idx = m_idx;
            e.at_tgt = (m_state == M_HOLD) ? 1 : 0;
            e.rdy    = (m_state != M_SEEK) ? 1 : 0;
            sb.push_back(e);
        end
        hs = sv && (m_state != M_SEEK);
        stepev = tick && (m_cnt == SP - 1);
        ns = m_state; cmd = 0; slew = 0;
        if (sp) begin
            ns = M_IDLE; cmd = 1;
        end else if (hs) begin
            ns = M_SEEK; cmd = 1; m_tgt = pos * (PER - 1) / 15;
        end else if (ss && m_state != M_SEEK) begin
            ns = M_SWEEP; cmd = 1; m_idx = 0;
        end else if (m_state == M_SWEEP && stepev) begin
            m_idx = (m_idx + 1) % 36;
        end else if (m_state == M_SEEK) begin
            if (m_duty == m_tgt) ns = M_HOLD;
            else if (stepev) slew = 1;
        end
        if (tick) begin
            if (ns == M_IDLE) m_duty = 0;
            else if (ns == M_SWEEP) m_duty = sine_tab[m_idx];
            else if (slew) m_duty = m_duty + ((m_tgt > m_duty) ? 1 : -1);
        end
        if (cmd || ns != m_state) m_cnt = 0;
        else if (tick) m_cnt = (m_cnt + 1) % SP;
        m_state = ns;
        m_q = (m_q + 1) % PER;
        if (tick) m_tick_seen = 1;
    endtask

    task automatic cyc(input bit ss, input bit sp, input bit sv, input int pos);
        sweep_start = ss; stop = sp; seek_valid = sv; pos_t = 4'(pos);
        model_cycle(ss, sp, sv, pos);
        @(posedge clk);
        #2;
        sweep_start = 1'b0; stop = 1'b0; seek_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic run_until_idx(input int want, input int budget);
        int n;
        n = 0;
        while (m_idx != want && n < budget) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk("step_idx_reach", int'(step_idx), want);
    endtask

    task automatic run_until_hold(input int budget);
        int n;
        n = 0;
        while (m_state != M_HOLD && n < budget) begin
            cyc(0, 0, 0, 0);
            n++;
        end
        chk("hold_state", int'(state), M_HOLD);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pwm_out"}, int'(pwm_out), 0);
        chk({tag, "_duty"}, int'(duty), 0);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_seek_ready"}, int'(seek_ready), 1);
        chk({tag, "_at_target"}, int'(at_target), 0);
        chk({tag, "_step_idx"}, int'(step_idx), 0);
    endtask

    // asserted between clock edges; outputs must clear without waiting for a clock
    task automatic async_reset();
        #1 rst = 1'b1;
        #1 check_reset_values("async_rst");
        @(posedge clk);
        #2 rst = 1'b0;
        sb.delete();
        model_reset();
    endtask

    // monitor: per period, compare DUT against the queued expectation and measure pwm high time
    initial begin : monitor
        int   hi;
        bit   mid;
        int   pduty;
        bit   ptick;
        exp_t e;
        hi = 0; mid = 0; pduty = 0; ptick = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi = 0; mid = 0; pduty = 0; ptick = 0;
            end else begin
                if (int'(duty) != pduty && !ptick) mid = 1;
                hi += int'(pwm_out);
                if (period_tick) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("period_duty", int'(duty), e.duty);
                        chk("period_state", int'(state), e.state);
                        chk("period_step_idx", int'(step_idx), e.idx);
                        chk("period_at_target", int'(at_target), e.at_tgt);
                        chk("period_seek_ready", int'(seek_ready), e.rdy);
                        chk("pwm_high_cycles", hi, e.duty);
                        chk("duty_mid_period_change", int'(mid), 0);
                    end
                    hi = 0;
                    mid = 0;
                end
                pduty = int'(duty);
                ptick = period_tick;
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "time limit");
    end

    initial begin : driver
        int r;
        for (int k = 0; k < 36; k++) sine_tab[k] = sine_ref(k);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_values("por");
        rst = 1'b0;

        // sweep from IDLE: first tick loads SINE[0], one step per two periods, wrap 35 -> 0
        m_tick_seen = 0;
        cyc(1, 0, 0, 0);
        while (!m_tick_seen) cyc(0, 0, 0, 0);
        chk("sweep_first_duty", int'(duty), 32);
        chk("sweep_state", int'(state), M_SWEEP);
        run_until_idx(1, 300);
        chk("sweep_step1_duty", int'(duty), 37);
        run_until_idx(9, 1200);
        chk("sweep_peak_duty", int'(duty), 63);
        run_until_idx(35, 4000);
        run_until_idx(0, 300);
        chk("sweep_wrap_duty", int'(duty), 32);

        // restart and reset asynchronously at step 7
        cyc(1, 0, 0, 0);
        run_until_idx(7, 1200);
        idle_cycles(int'($urandom_range(3, 40)));
        async_reset();

        // seek to code 1 from IDLE, ramp 0..4 then HOLD
        cyc(0, 0, 1, 1);
        chk("seek_ready_low", int'(seek_ready), 0);
        chk("seek_state", int'(state), M_SEEK);
        run_until_hold(2000);
        chk("hold_duty_4", int'(duty), 4);
        chk("hold_at_target", int'(at_target), 1);
        chk("hold_seek_ready", int'(seek_ready), 1);

        // ramp down to 0 without wrapping
        cyc(0, 0, 1, 0);
        run_until_hold(2000);
        chk("hold_duty_0", int'(duty), 0);

        // stop, seek and sweep_start together while sweeping: stop wins
        cyc(1, 0, 0, 0);
        idle_cycles(200);
        cyc(1, 1, 1, 5);
        chk("triple_cmd_state", int'(state), M_IDLE);
        chk("triple_cmd_ready", int'(seek_ready), 1);

        // seek to 33; a second request during SEEK is not accepted
        cyc(0, 0, 1, 8);
        idle_cycles(100);
        cyc(0, 0, 1, 15);
        chk("ignored_seek_state", int'(state), M_SEEK);
        run_until_hold(6000);
        chk("hold_duty_33", int'(duty), 33);

        // seek to 63 launched mid-period
        idle_cycles(int'($urandom_range(1, 62)));
        cyc(0, 0, 1, 15);
        run_until_hold(6000);
        chk("hold_duty_63", int'(duty), 63);
        idle_cycles(130);

        // equal target: SEEK for one cycle then back to HOLD
        cyc(0, 0, 1, 15);
        chk("equal_seek_state", int'(state), M_SEEK);
        cyc(0, 0, 0, 0);
        chk("equal_hold_state", int'(state), M_HOLD);

        // randomized command traffic checked per period by the monitor
        for (int i = 0; i < 8000; i++) begin
            r = int'($urandom_range(0, 299));
            cyc(r < 2, r == 2, (r >= 3) && (r < 6), int'($urandom_range(0, 15)));
        end
        idle_cycles(70);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_seq_ctrl.md
Name: pwm_seq_ctrl

Overview:
- Controller that sequences a single PWM compare datapath: owns the PWM counter and duty register, and decides what duty value the channel runs.
- Two duty sources:
  - SWEEP walks a 36-entry sine duty table, advancing one step every STEP_PERIODS PWM periods.
  - SEEK slews the duty 1 LSB per step toward a target derived from a 4-bit position code.
- Sits between the top-level user controls (buttons/position selector) and the PWM output pin.

Parameters:
- R, 6, PWM resolution in bits; PWM period = 2**R clk cycles.
- STEP_PERIODS, 4000, PWM periods per sweep step or slew step (range 1..65535).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- sweep_start  in  1  single-cycle pulse; start or restart the sine sweep at index 0.
- stop  in  1  single-cycle pulse; return to IDLE.
- pos_t  in  4  position code for SEEK; sampled on handshake.
- seek_valid  in  1  request a seek to pos_t.
- seek_ready  out  1  seek request accepted when seek_valid && seek_ready.
- pwm_out  out  1  PWM output.
- duty  out  R  current applied duty.
- state  out  2  0=IDLE, 1=SWEEP, 2=SEEK, 3=HOLD.
- step_idx  out  6  current sine table index, 0..35.
- period_tick  out  1  high on the last cycle of each PWM period (q == 2**R-1).
- at_target  out  1  high in HOLD.

Behaviour:
- Reset (async): q=0, duty=0, state=IDLE, step_idx=0, step counter=0, target=0, pwm_out=0, at_target=0, seek_ready=1.
- q counter:
  - Free-runs 0..2**R-1 in every state and wraps to 0.
  - pwm_out = (q < duty), driven from registers only.
- Duty updates only on period_tick; the new value applies from q=0 of the next period. No mid-period duty change is allowed.
- Step counter:
  - Counts period_ticks 0..STEP_PERIODS-1; step event = period_tick && count==STEP_PERIODS-1.
  - Cleared on every state entry and on sweep restart.
- Command priority when events coincide in one cycle: stop > seek handshake > sweep_start.
- IDLE: duty target is 0 (applied at the next period_tick). sweep_start -> SWEEP. Handshake -> SEEK.
- SWEEP:
  - On entry, step_idx=0; duty loads SINE[0] at the next period_tick.
  - Each step event: step_idx increments, 35 wraps to 0, and duty loads SINE[new idx] at that same tick.
  - Runs continuously.
  - sweep_start restarts at idx 0. Handshake -> SEEK. stop -> IDLE.
- SEEK:
  - target = POS2DUTY[pos_t], latched on handshake.
  - seek_ready=0 while in SEEK.
  - Each step event: duty moves 1 LSB toward target.
  - When duty==target (checked every cycle, including at entry) -> HOLD.
  - stop -> IDLE; sweep_start is ignored.
- HOLD: duty is constant and at_target=1. Handshake -> SEEK with the new target; equal target returns to HOLD next cycle. sweep_start -> SWEEP. stop -> IDLE.
- seek_ready=1 in IDLE, SWEEP and HOLD; 0 in SEEK.
- step_idx holds its value outside SWEEP and is cleared on SWEEP entry.
- Tables:
  - SINE[k] = floor(2**R*(0.5+0.5*sin(2*pi*k/36))), clipped to 2**R-1. For R=6: SINE[0]=32, SINE[9]=63, SINE[18]=32, SINE[27]=0.
  - POS2DUTY[p] = floor(p*(2**R-1)/15). For R=6: p=0->0, 1->4, 8->33, 15->63.
- Width rules: duty arithmetic is unsigned R bits. Slew never overshoots and never wraps.

Decomposition:
- Package pwm_seq_pkg holds:
  - state encoding constants;
  - table depth 36;
  - the SINE and POS2DUTY constant functions parameterised by R.
- One sub-module, pwm_core. It contains the q counter, period_tick, and the registered compare. It takes duty_next plus a load strobe and latches the new duty on period_tick.

Test Plan:
All scenarios use R=6 and STEP_PERIODS=2.
- Reset mid-SWEEP at step_idx=7: assert rst async -> same cycle pwm_out=0, duty=0, state=0, seek_ready=1.
- sweep_start in IDLE -> at the next period_tick duty=32. After 2 periods step_idx=1 and duty=SINE[1]. idx 35 wraps to 0. In every period, pwm_out is high for exactly duty cycles.
- Seek from IDLE with pos_t=1 -> seek_ready=0. duty steps 0,1,2,3,4, one step per 2 periods, then HOLD with at_target=1 and seek_ready=1.
- In HOLD at 4, seek pos_t=0 -> duty ramps down to 0 with no wrap to 63, then HOLD.
- sweep_start, stop and seek_valid all in one cycle while in SWEEP -> IDLE. seek_valid in SEEK with seek_ready=0 -> ignored and target unchanged.
- Seek with pos_t=15 started mid-period -> duty never changes except on period_tick. Final duty=63, and pwm_out is high 63 of 64 cycles.
